drain_scheduler: RTL and testbench
==================================

# drain_scheduler

Load scheduler for the flip-flop drainer banks. It steps a thermometer-coded enable mask across `NUM_BANKS` drainer instances so that switching load ramps up, holds, or sweeps up and back down on a fixed time base. This lets the HDMI output's stability be characterised against the load level. It sits in `top` beside the drainer banks; it drives their enables and a level indicator.

## Interface
Parameters:
- `NUM_BANKS`, default 8: number of drainer banks controlled; ≥1.
- `TICKS_PER_STEP`, default 27_000_000: `clk` cycles per level step (1 s at 27 MHz); ≥2.
- `LEVEL_W`, default `$clog2(NUM_BANKS+1)`: width of the level value.

Ports:
- `clk` in 1: single clock for the block.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to begin a run; sampled only in IDLE.
- `stop` in 1: abort; forces IDLE from any state.
- `sweep` in 1: sampled with `start`. 1 = up then down, then finish; 0 = up then hold.
- `frame_start` in 1: one-cycle pulse at video frame start; used only with `DRAIN_SCHED_FRAME_SYNC_EN`.
- `level` out `LEVEL_W`: current load level, 0..`NUM_BANKS`.
- `bank_en` out `NUM_BANKS`: thermometer mask; bit i = (i < `level`).
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a sweep returns to level 0.

## Operation
- States: IDLE, RAMP_UP, HOLD, RAMP_DOWN.
- Reset: state = IDLE; `level` = 0, `bank_en` = 0, `busy` = 0, `done` = 0; step timer = 0; pending flag cleared.
- IDLE + `start`: go to RAMP_UP at `level` 0, latch `sweep`, clear the timer.
- Step timer: counts 0..`TICKS_PER_STEP`-1 while in RAMP_UP or RAMP_DOWN. On the terminal count it raises a step event and wraps to 0.
- RAMP_UP step: `level` += 1. When the new level = `NUM_BANKS`, go to RAMP_DOWN if the latched sweep is 1, otherwise to HOLD.
- HOLD: `level` stays at `NUM_BANKS` and the timer is frozen. The block stays here until `stop` or `reset`.
- RAMP_DOWN step: `level` -= 1. When the new level = 0, assert `done` for that cycle and go to IDLE.
- `stop` (any state): next cycle state = IDLE, `level` = 0, timer cleared, pending cleared. No `done` pulse.
- `stop` and `start` in the same cycle: `stop` wins and the block stays IDLE.
- `start` while busy: ignored.
- Arithmetic: `level` never wraps. Increments saturate at `NUM_BANKS`; decrements stop at 0.
- `bank_en` and `level` are registered and updated on the same edge.

## Timing
- With `start` high at cycle 0: `busy` = 1 from cycle 1, and the first level change appears at cycle 1+`TICKS_PER_STEP`.
- Each later change follows `TICKS_PER_STEP` cycles after the previous one (free-running mode).
- `done` is high in the same cycle that `level` reads 0 and `busy` reads 0.
- Latency from `stop` to outputs at 0: 1 cycle.

## Configuration
- `DRAIN_SCHED_FRAME_SYNC_EN` defined:
  - A step event sets a pending flag and freezes the timer.
  - The level change and any state transition apply on the edge after the next `frame_start` pulse. The pending flag then clears and the timer restarts from 0.
  - A `frame_start` pulse that coincides with the step event applies it on that edge.
- `DRAIN_SCHED_FRAME_SYNC_EN` not defined: `frame_start` is ignored and level changes apply on the step-event edge.

## Structure
- Package `drain_sched_pkg`: state enum `drain_state_t` {IDLE, RAMP_UP, HOLD, RAMP_DOWN}.
- Sub-module `step_timer`:
  - Parameterised by `TICKS_PER_STEP`.
  - Inputs: `clk`, `reset`, `run`, `clear`.
  - Output: `tick`, one-cycle pulse at the terminal count.
- The FSM and the level register live in `drain_scheduler`.

## Test plan
All scenarios use `NUM_BANKS`=4 and `TICKS_PER_STEP`=4.
- Sweep, free-running (macro off): `start` with `sweep`=1 at cycle 0.
  - `level` reads 1, 2, 3, 4 at cycles 5, 9, 13, 17.
  - `level` reads 3, 2, 1, 0 at cycles 21, 25, 29, 33.
  - `done` pulses at cycle 33; `busy` is 0 from cycle 33.
  - `bank_en` at cycle 9 = 4'b0011.
- Step-up hold: `sweep`=0, `start` at cycle 0.
  - `level` = 4 from cycle 17 and stays at 4 through cycle 100.
  - `busy` = 1 throughout; `done` never pulses.
- Abort: `stop` at cycle 10 of a sweep.
  - At cycle 11: `level` = 0, `bank_en` = 0, `busy` = 0, and no `done`.
  - A new `start` at cycle 12 gives `level` 1 at cycle 17.
- Collisions:
  - `start` and `stop` together in IDLE: the block stays IDLE.
  - `start` at cycle 6 during a run: no effect on the level sequence.
- Reset mid-run: `reset` at cycle 14 sets all outputs to 0 at cycle 15; there is no `done` pulse.
- Frame sync (macro on), `frame_start` pulses at cycles 7 and 20, plus a second run:
  - With the step event at cycle 4, `level` = 1 at cycle 8, and the next step event occurs 4 cycles after that.
  - In a second run, a `frame_start` coincident with the step event applies the change on the next edge.

Source files
------------

// File: rtl/drain_sched_pkg.sv
// Shared types for the drainer-bank load scheduler.
package drain_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        HOLD,
        RAMP_DOWN
    } drain_state_t;

endpackage

// File: rtl/drain_scheduler_step_timer.sv
// Free-running step time base: pulses tick on the terminal count of a
// 0..TICKS_PER_STEP-1 counter while run is high, holds otherwise.
module step_timer #(
    parameter int TICKS_PER_STEP = 27_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(TICKS_PER_STEP);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_STEP - 1);

    logic [CNT_W-1:0] count;

    assign tick = run && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/drain_scheduler.sv
// Thermometer-coded load scheduler for the drainer banks.
// Optional feature: define DRAIN_SCHED_FRAME_SYNC_EN to align level steps to frame_start.
module drain_scheduler #(
    parameter int NUM_BANKS      = 8,
    parameter int TICKS_PER_STEP = 27_000_000,
    parameter int LEVEL_W        = $clog2(NUM_BANKS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 sweep,
    input  logic                 frame_start,
    output logic [LEVEL_W-1:0]   level,
    output logic [NUM_BANKS-1:0] bank_en,
    output logic                 busy,
    output logic                 done
);

    import drain_sched_pkg::*;

    localparam logic [LEVEL_W-1:0] MAX_LEVEL = LEVEL_W'(NUM_BANKS);

    drain_state_t         state, state_next;
    logic [LEVEL_W-1:0]   level_next;
    logic [NUM_BANKS-1:0] bank_en_next;
    logic                 sweep_latched, sweep_next;
    logic                 pending, pending_next;
    logic                 done_next;
    logic                 tick, run, timer_clear;
    logic                 apply, waiting;

    // The timer freezes while a step is waiting for its frame boundary.
    assign run  = ((state == RAMP_UP) || (state == RAMP_DOWN)) && !pending;
    assign busy = (state != IDLE);

`ifdef DRAIN_SCHED_FRAME_SYNC_EN
    assign apply   = (tick || pending) && frame_start;
    assign waiting = (tick || pending) && !frame_start;
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
    assign apply   = tick;
    assign waiting = 1'b0;
`endif

    step_timer #(
        .TICKS_PER_STEP(TICKS_PER_STEP)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clear (timer_clear),
        .tick  (tick)
    );

    always_comb begin
        state_next   = state;
        level_next   = level;
        sweep_next   = sweep_latched;
        pending_next = pending;
        done_next    = 1'b0;
        timer_clear  = 1'b0;

        if (stop) begin
            state_next   = IDLE;
            level_next   = '0;
            pending_next = 1'b0;
            timer_clear  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    pending_next = 1'b0;
                    if (start) begin
                        state_next  = RAMP_UP;
                        level_next  = '0;
                        sweep_next  = sweep;
                        timer_clear = 1'b1;
                    end
                end
                RAMP_UP: begin
                    pending_next = waiting;
                    if (apply) begin
                        timer_clear = 1'b1;
                        if (level < MAX_LEVEL) begin
                            level_next = level + LEVEL_W'(1);
                        end
                        if (level_next == MAX_LEVEL) begin
                            state_next = sweep_latched ? RAMP_DOWN : HOLD;
                        end
                    end
                end
                HOLD: begin
                    pending_next = 1'b0;
                end
                RAMP_DOWN: begin
                    pending_next = waiting;
                    if (apply) begin
                        timer_clear = 1'b1;
                        if (level != '0) begin
                            level_next = level - LEVEL_W'(1);
                        end
                        if (level_next == '0) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    level_next = '0;
                end
            endcase
        end
    end

    // The mask is derived from the next level so both registers move together.
    always_comb begin
        bank_en_next = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_en_next[i] = (LEVEL_W'(i) < level_next);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            level         <= '0;
            bank_en       <= '0;
            sweep_latched <= 1'b0;
            pending       <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_next;
            level         <= level_next;
            bank_en       <= bank_en_next;
            sweep_latched <= sweep_next;
            pending       <= pending_next;
            done          <= done_next;
        end
    end

endmodule

// File: tb/tb_drain_scheduler.sv
// Self-checking bench for drain_scheduler with NUM_BANKS=4, TICKS_PER_STEP=4.
// Build with DRAIN_SCHED_FRAME_SYNC_EN defined to exercise the frame-aligned mode.
module tb_drain_scheduler;

    localparam int NB = 4;
    localparam int T  = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          sweep = 1'b0;
    logic          frame_start = 1'b0;
    logic [LW-1:0] level;
    logic [NB-1:0] bank_en;
    logic          busy;
    logic          done;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference run: when active, outputs are a closed-form function of
    // the number of cycles since the start request was sampled.
    bit m_active = 0;
    bit m_sweep  = 0;
    int m_s0     = 0;
    logic [LW+NB+1:0] exp_vec;

    drain_scheduler #(
        .NUM_BANKS(NB),
        .TICKS_PER_STEP(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .sweep(sweep),
        .frame_start(frame_start),
        .level(level),
        .bank_en(bank_en),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [LW+NB+1:0] pack(int lvl, bit b, bit d);
        logic [NB-1:0] mask;
        mask = NB'((1 << lvl) - 1);
        return {LW'(lvl), mask, b, d};
    endfunction

    // Drive one cycle of inputs, predict the outputs of the following cycle.
    task automatic advance(input bit st, input bit sp, input bit sw, input bit rs);
        int k;
        start = st;
        stop = sp;
        sweep = sw;
        reset = rs;
        frame_start = 1'($urandom_range(0, 1));
        if (rs || sp) begin
            m_active = 0;
        end else if (!m_active && st) begin
            m_active = 1;
            m_sweep = sw;
            m_s0 = cyc;
        end
        if (!m_active) begin
            exp_vec = pack(0, 0, 0);
        end else begin
            k = (cyc - m_s0) / T;
            if (!m_sweep) begin
                exp_vec = pack((k < NB) ? k : NB, 1, 0);
            end else if (k <= NB) begin
                exp_vec = pack(k, 1, 0);
            end else if (k < 2 * NB) begin
                exp_vec = pack(2 * NB - k, 1, 0);
            end else begin
                exp_vec = pack(0, 0, 1);
                m_active = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        advance(0, 0, 0, 1);
        advance(1, 0, 1, 1);
        checks++;
        if ({level, bank_en, busy, done} !== 9'b0) begin
            fails++;
            $display("[TB] FAIL reset cyc=%0d got=%h exp=000", cyc, {level, bank_en, busy, done});
        end
        advance(0, 0, 0, 0);
    endtask

    task automatic test_sweep();
        advance(0, 1, 0, 0);
        for (int i = 0; i <= 36; i++) begin
            advance(i == 0, 0, 1, 0);
            checks++;
            if ({level, bank_en, busy, done} !== exp_vec) begin
                fails++;
                $display("[TB] FAIL sweep t=%0d got=%h exp=%h", i + 1, {level, bank_en, busy, done}, exp_vec);
            end
        end
    endtask

    task automatic test_hold();
        advance(0, 1, 0, 0);
        for (int i = 0; i <= 100; i++) begin
            advance(i == 0, 0, 0, 0);
            checks++;
            if ({level, bank_en, busy, done} !== exp_vec) begin
                fails++;
                $display("[TB] FAIL hold t=%0d got=%h exp=%h", i + 1, {level, bank_en, busy, done}, exp_vec);
            end
        end
    endtask

    task automatic test_abort();
        advance(0, 1, 0, 0);
        for (int i = 0; i <= 24; i++) begin
            advance(i == 0 || i == 12, i == 10, 1, 0);
            checks++;
            if ({level, bank_en, busy, done} !== exp_vec) begin
                fails++;
                $display("[TB] FAIL abort t=%0d got=%h exp=%h", i + 1, {level, bank_en, busy, done}, exp_vec);
            end
        end
    endtask

    task automatic test_collisions();
        advance(0, 1, 0, 0);
        for (int i = 0; i <= 30; i++) begin
            advance(i == 0 || i == 3 || i == 6, i == 0, 1, 0);
            checks++;
            if ({level, bank_en, busy, done} !== exp_vec) begin
                fails++;
                $display("[TB] FAIL collide t=%0d got=%h exp=%h", i + 1, {level, bank_en, busy, done}, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        advance(0, 1, 0, 0);
        for (int i = 0; i <= 22; i++) begin
            advance(i == 0, 0, 1, i == 14);
            checks++;
            if ({level, bank_en, busy, done} !== exp_vec) begin
                fails++;
                $display("[TB] FAIL midreset t=%0d got=%h exp=%h", i + 1, {level, bank_en, busy, done}, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        bit st, sp, sw, rs;
        advance(0, 1, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 49) == 0);
            rs = ($urandom_range(0, 120) == 0);
            sw = 1'($urandom_range(0, 1));
            advance(st, sp, sw, rs);
            checks++;
            if ({level, bank_en, busy, done} !== exp_vec) begin
                fails++;
                $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc, {level, bank_en, busy, done}, exp_vec);
            end
        end
    endtask

    // Frame-aligned mode: step events wait for frame_start, then the timer restarts.
    task automatic test_frame_sync();
        int want;
        reset = 0;
        stop = 1;
        @(posedge clk);
        #1;
        stop = 0;
        for (int i = 0; i <= 24; i++) begin
            start = (i == 0);
            sweep = 1;
            frame_start = (i == 7 || i == 20);
            @(posedge clk);
            #1;
            want = -1;
            if (i + 1 == 7)  want = 0;
            if (i + 1 == 8)  want = 1;
            if (i + 1 == 15) want = 1;
            if (i + 1 == 20) want = 1;
            if (i + 1 == 21) want = 2;
            if (want >= 0) begin
                checks++;
                if (level !== LW'(want)) begin
                    fails++;
                    $display("[TB] FAIL fsync1 t=%0d got=%0d exp=%0d", i + 1, level, want);
                end
            end
        end
        start = 0;
        frame_start = 0;
        stop = 1;
        @(posedge clk);
        #1;
        stop = 0;
        for (int j = 0; j <= 6; j++) begin
            start = (j == 0);
            frame_start = (j == 4);
            @(posedge clk);
            #1;
            want = -1;
            if (j + 1 == 4) want = 0;
            if (j + 1 == 5) want = 1;
            if (j + 1 == 7) want = 1;
            if (want >= 0) begin
                checks++;
                if (level !== LW'(want) || busy !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL fsync2 t=%0d got=%0d/%b exp=%0d/1", j + 1, level, busy, want);
                end
            end
        end
    endtask

    initial begin
        $display("[TB] drain_scheduler bench start");
        test_reset();
`ifdef DRAIN_SCHED_FRAME_SYNC_EN
        test_frame_sync();
`else
        test_sweep();
        test_hold();
        test_abort();
        test_collisions();
        test_reset_mid_run();
        test_random();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
